// File: rtl/neuron_output_packer.sv
// neuron_output_packer
//   Collects one signed accumulator sum per output neuron (neuron order
//   0..NUM_NEURONS-1) over a valid/ready handshake. Each sum is quantized
//   (ReLU, arithmetic shift right, unsigned saturation to OUT_W bits) and
//   stored in its slot. When the last slot of a frame is filled, the packed
//   frame is published on neuron_outputs with a one-cycle out_valid pulse.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   in_valid        in_data/in_first are valid
//   in_ready        beat can be accepted this cycle (registered state only)
//   in_data         signed accumulator sum for the current neuron
//   in_first        beat is neuron 0 of a new frame (resyncs a partial frame)
//   out_valid       one-cycle pulse, neuron_outputs holds a complete frame
//   neuron_outputs  packed frame, neuron i at [i*OUT_W +: OUT_W]
//   sync_err        one-cycle pulse, a partial frame was dropped on in_first
//   frame_cnt       number of frames emitted, wraps at 2^16
module neuron_output_packer #(
  parameter int NUM_NEURONS = 10,
  parameter int ACC_W       = 16,
  parameter int OUT_W       = 4,
  parameter int SHIFT       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [ACC_W-1:0]      in_data,
  input  logic                         in_first,
  output logic                         out_valid,
  output logic [NUM_NEURONS*OUT_W-1:0] neuron_outputs,
  output logic                         sync_err,
  output logic [15:0]                  frame_cnt
);

  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int CW    = ACC_W + OUT_W;

  localparam logic [0:0] S_COLLECT = 1'b0;
  localparam logic [0:0] S_EMIT    = 1'b1;

  // Saturation limit widened so the compare sees every bit of the shifted sum.
  localparam logic [CW-1:0]    QMAX = {{ACC_W{1'b0}}, {OUT_W{1'b1}}};
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

  logic [0:0]                         state;
  logic [IDX_W-1:0]                   idx;
  logic [NUM_NEURONS-1:0][OUT_W-1:0]  staging;
  logic [NUM_NEURONS-1:0][OUT_W-1:0]  out_img;

  logic signed [ACC_W-1:0] shifted;
  logic [CW-1:0]           v_ext;
  logic [OUT_W-1:0]        q;
  logic                    accept;
  logic                    resync;
  logic                    last;

  assign in_ready       = (state == S_COLLECT);
  assign accept         = in_valid && in_ready;
  // idx is always 0 with a single neuron, so resync can never fire there.
  assign resync         = in_first && (idx != '0);
  assign last           = (idx == LAST);
  assign neuron_outputs = out_img;

  // ReLU -> shift -> saturate. Negative sums short-circuit to zero, so the
  // shifted value is non-negative whenever it is used and zero-extends safely.
  always_comb begin
    shifted = in_data >>> SHIFT;
    v_ext   = CW'($unsigned(shifted));
    q       = '0;
    if (!in_data[ACC_W-1])
      q = (v_ext > QMAX) ? QMAX[OUT_W-1:0] : v_ext[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_COLLECT;
      idx       <= '0;
      staging   <= '0;
      out_img   <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
      if (state == S_EMIT)
        state <= S_COLLECT;
      if (accept) begin
        if (resync) begin
          // Drop the partial frame; this beat becomes neuron 0 of the new one.
          staging    <= '0;
          staging[0] <= q;
          idx        <= IDX_W'(1);
          sync_err   <= 1'b1;
        end else if (last) begin
          // Final beat bypasses staging and lands directly in the output image,
          // so the frame is visible in the same cycle as out_valid.
          out_img                <= staging;
          out_img[NUM_NEURONS-1] <= q;
          staging                <= '0;
          idx                    <= '0;
          state                  <= S_EMIT;
          out_valid              <= 1'b1;
          frame_cnt              <= frame_cnt + 16'd1;
        end else begin
          for (int i = 0; i < NUM_NEURONS; i++)
            if (idx == IDX_W'(i))
              staging[i] <= q;
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/neuron_output_packer.md
Name: neuron_output_packer

Overview:
Producer side of the packed neuron-output interface consumed by the argmax stage. Accepts one signed accumulator sum per output neuron, serially, in neuron order 0..NUM_NEURONS-1, over a valid/ready handshake. Each sum is passed through ReLU, shifted right and saturated to an OUT_W-bit unsigned activation, then stored in its slot. When all slots of a frame are filled, the block emits the packed vector with a single-cycle out_valid pulse.

Parameters:
NUM_NEURONS, 10, number of output neurons per frame (>=1)
ACC_W, 16, width of the signed accumulator input
OUT_W, 4, width of each quantized unsigned output
SHIFT, 4, arithmetic right-shift applied before saturation (0..ACC_W-1)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
in_valid  input  1  in_data/in_first valid
in_ready  output  1  block can accept a beat this cycle
in_data  input  ACC_W  signed accumulator sum for the current neuron
in_first  input  1  beat is neuron 0 of a new frame
out_valid  output  1  one-cycle pulse: neuron_outputs holds a complete frame
neuron_outputs  output  NUM_NEURONS*OUT_W  packed outputs; neuron i at bits [i*OUT_W +: OUT_W]
sync_err  output  1  one-cycle pulse: partial frame discarded on in_first
frame_cnt  output  16  count of emitted frames, wraps at 2^16

Behaviour:
- Reset values: state=COLLECT, idx=0, staging=0, out_valid=0, neuron_outputs=0, sync_err=0, frame_cnt=0. in_ready=1 in the first cycle after rst deasserts.
- in_ready = (state==COLLECT). It is derived from registered state only and has no combinational path from in_valid.
- A beat is accepted when in_valid && in_ready.
- Quantize q:
  - in_data < 0 gives q=0.
  - Otherwise v = in_data >>> SHIFT; q = min(v, 2^OUT_W-1).
  - Full-width compare, no truncation before saturation.
- Accepted beat, in_first=0: staging[idx] <= q; idx <= idx+1.
- Accepted beat, in_first=1, idx==0: handled as a normal beat.
- Accepted beat, in_first=1, idx!=0:
  - Partial frame discarded. All staging slots are cleared except slot 0.
  - staging[0] <= q; idx <= 1.
  - sync_err=1 on the next cycle, for one cycle only.
  - frame_cnt is unchanged.
- Accepted beat that fills slot NUM_NEURONS-1 (not a resync case):
  - State goes to EMIT; idx <= 0.
  - The final q is written straight into the output image.
- EMIT (exactly one cycle, next cycle after the last accept):
  - out_valid=1, neuron_outputs = complete frame, in_ready=0.
  - Then state returns to COLLECT.
- Staging is cleared at emission.
- frame_cnt increments in the same cycle out_valid is high.
- Latency: last beat accepted in cycle t gives out_valid in t+1; in_ready returns high in t+2. Minimum frame period is NUM_NEURONS+1 cycles.
- neuron_outputs changes only on emission. It holds its value between frames and through partial frames and resyncs.
- in_valid while in_ready=0: the beat is not accepted, and the source must hold it.
- NUM_NEURONS=1: every accepted beat causes an emission. in_first is irrelevant and sync_err never fires.
- rst mid-frame or during EMIT discards everything. Outputs return to reset values in the next cycle and no pulse is emitted.
- out_valid and sync_err are never high in the same cycle.

Test Plan:
1. Defaults: rst 2 cycles, then 10 beats with in_data=16*i, in_first on i=0, in_valid held → out_valid exactly 1 cycle, at the cycle after beat 9; neuron_outputs=0x9876543210; frame_cnt=1; in_ready low only during that cycle.
2. Saturation/ReLU: beats 0x0035, 0x0100, 0xFFFB (-5), 0x7FFF, 0x000F, then 5 beats of 0 → slots 0..4 = 3, 15, 0, 15, 0; neuron_outputs=0x000000F0F3.
3. Backpressure/gaps: random in_valid gaps, plus in_valid asserted during the EMIT cycle → that beat is accepted in the following cycle as neuron 0 of the next frame; no beat is lost or duplicated over 5 frames; frame_cnt=5.
4. Resync: 4 beats (in_first on the first), then in_first with in_data=0x0020 plus 9 further beats of 0x0010 → sync_err pulses once, one cycle after the second in_first; emitted frame=0x1111111112.
5. Mid-frame reset: rst asserted after 6 beats → no out_valid; neuron_outputs=0, frame_cnt=0; a following full frame emits correctly.
6. Back-to-back: 3 frames with in_valid held constantly → out_valid period is 11 cycles; each frame's neuron_outputs is stable until the next pulse.
